serial_twoc_array: RTL and testbench

Multi-channel, word-framed, bit-serial two's-complement negator. Parametrised successor to the single-lane serial inverter: CHANNELS independent lanes share one bit-position counter, receive LSB-first words of WIDTH bits, and per word and per lane either pass the word through or emit its two's complement. Adds valid-qualified input with gaps, word framing, a per-word negate mask and overflow flagging for the most-negative value. Sits between the serial data sources and the serial accumulators on the t_clk domain.

---
 rtl/serial_twoc_pkg.sv | 21 ++
 rtl/serial_twoc_array_if.sv | 26 ++
 rtl/serial_twoc_lane.sv | 52 +++++
 rtl/serial_twoc_array.sv | 73 +++++++
 tb/tb_serial_twoc_array.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_twoc_pkg.sv
// rtl/serial_twoc_pkg.sv - shared parameter helpers for the serial two's-complement lane array
// Contents: pos_width() sizes the shared bit-position counter,
//           params_legal() guards the supported WIDTH/CHANNELS ranges.
package serial_twoc_pkg;

  localparam int WIDTH_MIN    = 2;
  localparam int WIDTH_MAX    = 64;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 32;

  // Counter width for positions 0..width-1; never below one bit.
  function automatic int pos_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  function automatic bit params_legal(input int width, input int channels);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX);
  endfunction

endpackage

// File: rtl/serial_twoc_array_if.sv
// rtl/serial_twoc_array_if.sv - serial lane bundle between sources and the negator array
// Signals: in_valid/in_bits/neg_mask flow source -> array,
//          out_valid/out_bits/out_first/out_last/ovf flow array -> accumulators.
// Modports: master = serial source/sink side, slave = negator array.
interface serial_twoc_array_if #(
  parameter int CHANNELS = 4
);
  logic                in_valid;
  logic [CHANNELS-1:0] in_bits;
  logic [CHANNELS-1:0] neg_mask;
  logic                out_valid;
  logic [CHANNELS-1:0] out_bits;
  logic                out_first;
  logic                out_last;
  logic [CHANNELS-1:0] ovf;

  modport master (
    output in_valid, in_bits, neg_mask,
    input  out_valid, out_bits, out_first, out_last, ovf
  );

  modport slave (
    input  in_valid, in_bits, neg_mask,
    output out_valid, out_bits, out_first, out_last, ovf
  );
endinterface

// File: rtl/serial_twoc_lane.sv
// rtl/serial_twoc_lane.sv - one bit-serial pass/negate lane
// Ports: t_clk, r (async active-high reset), in_valid, in_bit, first/last (word position
//        flags from the shared counter), neg_sel (lane's neg_mask bit),
//        out_bit, ovf (both registered, forced to 0 on invalid cycles).
module serial_twoc_lane (
  input  logic t_clk,
  input  logic r,
  input  logic in_valid,
  input  logic in_bit,
  input  logic first,
  input  logic last,
  input  logic neg_sel,
  output logic out_bit,
  output logic ovf
);

  logic neg_q;
  logic seen_one;
  logic neg_eff;
  logic seen_eff;
  logic out_nxt;
  logic ovf_nxt;

  // On the first bit of a word the fresh mask and a cleared history apply in the
  // same cycle, so back-to-back words need no idle slot.
  assign neg_eff  = first ? neg_sel : neg_q;
  assign seen_eff = first ? 1'b0 : seen_one;

  // Serial negate: copy bits up to and including the lowest 1, invert the rest.
  assign out_nxt = (neg_eff && seen_eff) ? ~in_bit : in_bit;

  // Only 100..0 reaches the MSB with no earlier 1 and a 1 in the MSB.
  assign ovf_nxt = last && neg_eff && !seen_eff && in_bit;

  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      neg_q    <= 1'b0;
      seen_one <= 1'b0;
      out_bit  <= 1'b0;
      ovf      <= 1'b0;
    end else if (in_valid) begin
      neg_q    <= neg_eff;
      seen_one <= seen_eff | in_bit;
      out_bit  <= out_nxt;
      ovf      <= ovf_nxt;
    end else begin
      out_bit  <= 1'b0;
      ovf      <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_twoc_array.sv
// rtl/serial_twoc_array.sv - multi-lane word-framed bit-serial two's-complement negator
// Ports: t_clk, r (async active-high reset), bus (slave modport of serial_twoc_array_if).
// Parameters: WIDTH bits per LSB-first word (2..64), CHANNELS lanes (1..32).
// Latency is one cycle; outputs are zero whenever out_valid is low.
module serial_twoc_array
  import serial_twoc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic               t_clk,
  input  logic               r,
  serial_twoc_array_if.slave bus
);

  localparam int  POS_W     = pos_width(WIDTH);
  localparam bit  PARAMS_OK = params_legal(WIDTH, CHANNELS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIDTH - 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("serial_twoc_array: WIDTH or CHANNELS outside supported range");
  end

  logic [POS_W-1:0]    pos;
  logic                first;
  logic                last;
  logic                out_valid_q;
  logic                out_first_q;
  logic                out_last_q;
  logic [CHANNELS-1:0] lane_out;
  logic [CHANNELS-1:0] lane_ovf;

  assign first = (pos == '0);
  assign last  = (pos == LAST_POS);

  // Shared position counter; frozen on gap cycles so gaps never split framing.
  always_ff @(posedge t_clk or posedge r) begin
    if (r) begin
      pos         <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      out_first_q <= bus.in_valid && first;
      out_last_q  <= bus.in_valid && last;
      if (bus.in_valid) begin
        pos <= last ? '0 : pos + POS_W'(1);
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    serial_twoc_lane u_lane (
      .t_clk    (t_clk),
      .r        (r),
      .in_valid (bus.in_valid),
      .in_bit   (bus.in_bits[c]),
      .first    (first),
      .last     (last),
      .neg_sel  (bus.neg_mask[c]),
      .out_bit  (lane_out[c]),
      .ovf      (lane_ovf[c])
    );
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_bits  = lane_out;
  assign bus.ovf       = lane_ovf;

endmodule

// File: tb/tb_serial_twoc_array.sv
// tb/tb_serial_twoc_array.sv - self-checking bench for serial_twoc_array (WIDTH=8, CHANNELS=4)
module tb_serial_twoc_array;

  localparam int W = 8;
  localparam int C = 4;

  logic t_clk = 1'b0;
  logic r     = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  serial_twoc_array_if #(.CHANNELS(C)) bus ();

  serial_twoc_array #(.WIDTH(W), .CHANNELS(C)) dut (
    .t_clk (t_clk),
    .r     (r),
    .bus   (bus)
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [C*W-1:0] words;
    logic [C-1:0]   mask;
    logic [C-1:0]   mask_mid;
    logic [W-1:0]   gaps;
    logic [C*W-1:0] exp_words;
    logic [C-1:0]   exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_bits"},  64'(bus.out_bits),  64'd0);
    check({name, "_first"}, 64'(bus.out_first), 64'd0);
    check({name, "_last"},  64'(bus.out_last),  64'd0);
    check({name, "_ovf"},   64'(bus.ovf),       64'd0);
  endtask

  // Reference: pass or -x mod 2^W; overflow only when negating 100..0.
  function automatic logic [W-1:0] ref_word(input logic [W-1:0] x, input logic neg);
    return neg ? W'(-x) : x;
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic neg);
    return neg && (x == {1'b1, {(W-1){1'b0}}});
  endfunction

  // Sends one word on all lanes (bit 0 with mask, later bits with mask_mid),
  // inserts glen idle cycles after each bit flagged in gaps, checks framing per bit
  // and the reassembled words/overflow at the end.
  task automatic run_word(input string name, input logic [C*W-1:0] words,
                          input logic [C-1:0] mask, input logic [C-1:0] mask_mid,
                          input logic [W-1:0] gaps, input int glen,
                          input logic [C*W-1:0] exp_words, input logic [C-1:0] exp_ovf);
    logic [C*W-1:0] got;
    logic [C-1:0]   got_ovf;
    got     = '0;
    got_ovf = '0;
    for (int b = 0; b < W; b++) begin
      @(negedge t_clk);
      bus.in_valid = 1'b1;
      for (int c = 0; c < C; c++) bus.in_bits[c] = words[c*W + b];
      bus.neg_mask = (b == 0) ? mask : mask_mid;
      @(posedge t_clk);
      #1;
      check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({name, "_first"}, 64'(bus.out_first), 64'(b == 0));
      check({name, "_last"},  64'(bus.out_last),  64'(b == W - 1));
      for (int c = 0; c < C; c++) got[c*W + b] = bus.out_bits[c];
      if (b == W - 1) got_ovf = bus.ovf;
      else check({name, "_ovf_early"}, 64'(bus.ovf), 64'd0);
      if (gaps[b]) begin
        for (int g = 0; g < glen; g++) begin
          @(negedge t_clk);
          bus.in_valid = 1'b0;
          bus.in_bits  = C'($urandom);
          bus.neg_mask = C'($urandom);
          @(posedge t_clk);
          #1;
          check_idle({name, "_gap"});
        end
      end
    end
    check({name, "_word"}, 64'(got), 64'(exp_words));
    check({name, "_ovf"},  64'(got_ovf), 64'(exp_ovf));
  endtask

  task automatic idle_cycle();
    @(negedge t_clk);
    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    bus.neg_mask = '0;
  endtask

  initial begin
    logic [C*W-1:0] rw;
    logic [C*W-1:0] ew;
    logic [C-1:0]   rm;
    logic [C-1:0]   eo;
    logic [W-1:0]   rg;
    logic [W-1:0]   lw;

    // lane c word occupies words[c*8 +: 8]; lane 0 is rightmost byte.
    vecs[0] = '{words: 32'h7F_3C_A5_06, mask: 4'b0001, mask_mid: 4'b0001, gaps: 8'h00,
                exp_words: 32'h7F_3C_A5_FA, exp_ovf: 4'b0000};
    vecs[1] = '{words: 32'h01_00_80_55, mask: 4'b1110, mask_mid: 4'b1110, gaps: 8'h00,
                exp_words: 32'hFF_00_80_55, exp_ovf: 4'b0010};
    vecs[2] = '{words: 32'h35_35_35_35, mask: 4'b1111, mask_mid: 4'b1111, gaps: 8'h24,
                exp_words: 32'hCB_CB_CB_CB, exp_ovf: 4'b0000};
    vecs[3] = '{words: 32'h80_FF_80_01, mask: 4'b1011, mask_mid: 4'b0100, gaps: 8'h81,
                exp_words: 32'h80_FF_80_FF, exp_ovf: 4'b1010};

    bus.in_valid = 1'b0;
    bus.in_bits  = '0;
    bus.neg_mask = '0;
    repeat (2) @(posedge t_clk);
    #1;
    check_idle("reset");
    @(negedge t_clk);
    r = 1'b0;
    idle_cycle();
    @(posedge t_clk);
    #1;
    check_idle("post_reset_idle");

    for (int i = 0; i < 4; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].words, vecs[i].mask, vecs[i].mask_mid,
               vecs[i].gaps, 3, vecs[i].exp_words, vecs[i].exp_ovf);
    end

    // Back-to-back: mask 1->0 mid first word is ignored; second word uses its own bit-0 mask.
    run_word("b2b_a", 32'h01_01_01_01, 4'b0001, 4'b0000, 8'h00, 0,
             32'h01_01_01_FF, 4'b0000);
    run_word("b2b_b", 32'h02_02_02_02, 4'b0100, 4'b1011, 8'h00, 0,
             32'h02_FE_02_02, 4'b0000);

    // Reset mid-word: 4 bits of 0x0F, then r while in_valid=1.
    for (int b = 0; b < 4; b++) begin
      @(negedge t_clk);
      bus.in_valid = 1'b1;
      bus.in_bits  = '1;
      bus.neg_mask = '1;
    end
    @(posedge t_clk);
    #1;
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    @(negedge t_clk);
    r = 1'b1;
    #1;
    check_idle("async_reset");
    @(posedge t_clk);
    #1;
    check_idle("reset_drop");
    @(negedge t_clk);
    r = 1'b0;
    bus.in_valid = 1'b0;
    run_word("after_reset", 32'h03_03_03_03, 4'b1111, 4'b1111, 8'h00, 0,
             32'hFD_FD_FD_FD, 4'b0000);

    // Randomised words, masks, mid-word mask noise and gaps.
    for (int n = 0; n < 1000; n++) begin
      rw = '0;
      ew = '0;
      eo = '0;
      rm = C'($urandom);
      for (int c = 0; c < C; c++) begin
        case ($urandom_range(0, 7))
          0:       lw = {1'b1, {(W-1){1'b0}}};
          1:       lw = '0;
          default: lw = W'($urandom);
        endcase
        rw[c*W +: W] = lw;
        ew[c*W +: W] = ref_word(lw, rm[c]);
        eo[c]        = ref_ovf(lw, rm[c]);
      end
      rg = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      run_word("rand", rw, rm, C'($urandom), rg, $urandom_range(1, 3), ew, eo);
    end

    idle_cycle();
    @(posedge t_clk);
    #1;
    check_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
